// File: rtl/perf_event_counter_bank.sv
// N-channel event counter bank with cycle counter, run/freeze control and a
// one-cycle-latency registered read port. Channels wrap or saturate per SAT_MASK.
module perf_event_counter_bank #(
  parameter int                NUM_CH   = 8,
  parameter int                CNT_W    = 32,
  parameter logic [NUM_CH-1:0] SAT_MASK = '0,
  parameter int                SEL_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              clear,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic [NUM_CH-1:0] ovf,
  output logic              running,
  output logic              frozen
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] evCnt [NUM_CH];
  logic [CNT_W-1:0] cycleCnt;
  logic [CNT_W-1:0] rdMux;
  logic             selErr;

  // running/frozen are updated alongside state so they decode it with no comb delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (halt) begin
          state   <= FROZEN;
          running <= 1'b0;
          frozen  <= 1'b1;
        end
        FROZEN: ;
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      endcase
    end
  end

  // The halt cycle is still a RUN cycle, so it counts before the freeze lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) evCnt[i] <= '0;
      cycleCnt <= '0;
      ovf      <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_CH; i++) evCnt[i] <= '0;
      cycleCnt <= '0;
      ovf      <= '0;
    end else if (state == RUN) begin
      cycleCnt <= cycleCnt + CNT_W'(1);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (event_in[i]) begin
          if (evCnt[i] == '1) begin
            ovf[i] <= 1'b1;
            if (!SAT_MASK[i]) evCnt[i] <= '0;
          end else begin
            evCnt[i] <= evCnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    rdMux = '0;
    if (32'(rd_sel) == NUM_CH) rdMux = cycleCnt;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_sel) == i) rdMux = evCnt[i];
    end
  end

  assign selErr = 32'(rd_sel) > NUM_CH;

  // Read samples pre-edge counter values, so a read coinciding with clear sees old data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && selErr;
      if (rd_req) rd_data <= rdMux;
    end
  end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Bench for perf_event_counter_bank: a 32-bit wrapping instance and an 8-bit
// instance with channel 1 saturating, both driven by the same stimulus.
module tb_perf_event_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, halt, clear, rd_req;
  logic [7:0] event_in;
  logic [3:0] rd_sel;

  logic        validA, errA, runA, frzA;
  logic [31:0] dataA;
  logic [7:0]  ovfA;
  logic        validB, errB, runB, frzB;
  logic [7:0]  dataB;
  logic [7:0]  ovfB;

  perf_event_counter_bank #(.NUM_CH(8), .CNT_W(32), .SAT_MASK(8'h00), .SEL_W(4)) dutA (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .event_in(event_in), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(validA), .rd_data(dataA), .rd_err(errA), .ovf(ovfA),
    .running(runA), .frozen(frzA)
  );

  perf_event_counter_bank #(.NUM_CH(8), .CNT_W(8), .SAT_MASK(8'h02), .SEL_W(4)) dutB (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .event_in(event_in), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(validB), .rd_data(dataB), .rd_err(errB), .ovf(ovfB),
    .running(runB), .frozen(frzB)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  b;
    logic        err;
    string       name;
  } rdExp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] expData;
    logic        expErr;
  } rdVec_t;

  rdExp_t expQ[$];
  rdVec_t tbl[10];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic doRead(string name, logic [3:0] sel, logic [31:0] a, logic [7:0] b, logic err);
    rdExp_t e;
    e.a = a; e.b = b; e.err = err; e.name = name;
    rd_req = 1'b1;
    rd_sel = sel;
    expQ.push_back(e);
    step();
  endtask

  task automatic endRead();
    rd_req = 1'b0;
    step();
    #1 check("queue_drained", 64'(expQ.size()), 64'd0);
  endtask

  // Response monitor: every rd_valid must match the oldest outstanding request
  always @(negedge clk) begin
    rdExp_t e;
    if (validA || validB) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid actual=1 required=0");
      end else begin
        e = expQ.pop_front();
        check({e.name, "_validA"}, 64'(validA), 64'd1);
        check({e.name, "_validB"}, 64'(validB), 64'd1);
        check({e.name, "_dataA"}, 64'(dataA), 64'(e.a));
        check({e.name, "_dataB"}, 64'(dataB), 64'(e.b));
        check({e.name, "_errA"}, 64'(errA), 64'(e.err));
        check({e.name, "_errB"}, 64'(errB), 64'(e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'd0, 32'd10, 1'b0};
    tbl[1] = '{4'd1, 32'd0,  1'b0};
    tbl[2] = '{4'd2, 32'd10, 1'b0};
    tbl[3] = '{4'd3, 32'd0,  1'b0};
    tbl[4] = '{4'd4, 32'd0,  1'b0};
    tbl[5] = '{4'd5, 32'd0,  1'b0};
    tbl[6] = '{4'd6, 32'd0,  1'b0};
    tbl[7] = '{4'd7, 32'd0,  1'b0};
    tbl[8] = '{4'd8, 32'd10, 1'b0};
    tbl[9] = '{4'd9, 32'd0,  1'b1};

    rst = 1'b0; start = 1'b0; halt = 1'b0; clear = 1'b0;
    rd_req = 1'b0; rd_sel = '0; event_in = '0;
    step(); step();
    check("rst_valid", 64'(validA), 64'd0);
    check("rst_data", 64'(dataA), 64'd0);
    check("rst_ovf", 64'(ovfA), 64'd0);
    check("rst_running", 64'(runA), 64'd0);
    check("rst_frozen", 64'(frzA), 64'd0);
    rst = 1'b1;
    step();

    // count: 10 RUN cycles of event pattern 0101, halt on the 10th
    start = 1'b1; step(); start = 1'b0;
    check("t2_running", 64'(runA), 64'd1);
    for (int i = 0; i < 10; i++) begin
      event_in = 8'b0000_0101;
      halt = (i == 9);
      step();
    end
    event_in = '0; halt = 1'b0;
    check("t2_frozen", 64'(frzA), 64'd1);
    check("t2_not_running", 64'(runA), 64'd0);

    // frozen: events ignored
    event_in = 8'hFF;
    repeat (5) step();
    event_in = '0;
    doRead("t3_ch0", 4'd0, 32'd10, 8'd10, 1'b0);
    doRead("t3_cyc", 4'd8, 32'd10, 8'd10, 1'b0);
    endRead();
    check("t3_idle_valid", 64'(validA), 64'd0);
    check("t3_hold_data", 64'(dataA), 64'd10);
    check("t3_idle_err", 64'(errA), 64'd0);

    // back-to-back reads over all selects
    for (int i = 0; i < 10; i++)
      doRead($sformatf("t5_sel%0d", i), tbl[i].sel, tbl[i].expData, tbl[i].expData[7:0], tbl[i].expErr);
    endRead();

    // priority: clear beats halt/start, pending read returns pre-clear value
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    event_in = 8'h01;
    repeat (3) step();
    event_in = '0;
    clear = 1'b1; halt = 1'b1; start = 1'b1;
    doRead("t6_pending", 4'd0, 32'd3, 8'd3, 1'b0);
    clear = 1'b0; halt = 1'b0; start = 1'b0;
    endRead();
    check("t6_clr_running", 64'(runA), 64'd0);
    check("t6_clr_frozen", 64'(frzA), 64'd0);
    doRead("t6_ch0_zero", 4'd0, 32'd0, 8'd0, 1'b0);
    doRead("t6_cyc_zero", 4'd8, 32'd0, 8'd0, 1'b0);
    endRead();
    start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
    check("t6_start_wins", 64'(runA), 64'd1);
    check("t6_no_freeze", 64'(frzA), 64'd0);
    step(); step();
    doRead("t6_run_read", 4'd8, 32'd2, 8'd2, 1'b0);
    rd_req = 1'b0; halt = 1'b1; step(); halt = 1'b0;
    check("t6_halt_frozen", 64'(frzA), 64'd1);
    doRead("t6_halt_counts", 4'd8, 32'd4, 8'd4, 1'b0);
    endRead();

    // wrap vs saturate over 257 events
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 257; i++) begin
      event_in = 8'h03;
      halt = (i == 256);
      step();
    end
    event_in = '0; halt = 1'b0;
    check("t4_ovfA", 64'(ovfA), 64'h00);
    check("t4_ovfB", 64'(ovfB), 64'h03);
    check("t4_frozenB", 64'(frzB), 64'd1);
    doRead("t4_ch0", 4'd0, 32'd257, 8'd1, 1'b0);
    doRead("t4_ch1", 4'd1, 32'd257, 8'd255, 1'b0);
    doRead("t4_ch2", 4'd2, 32'd0, 8'd0, 1'b0);
    doRead("t4_cyc", 4'd8, 32'd257, 8'd1, 1'b0);
    endRead();
    clear = 1'b1; step(); clear = 1'b0;
    check("t4_ovf_cleared", 64'(ovfB), 64'h00);

    // async reset mid-RUN with a read response in flight
    start = 1'b1; step(); start = 1'b0;
    event_in = 8'hFF;
    repeat (4) step();
    event_in = '0;
    rd_req = 1'b1; rd_sel = 4'd0;
    @(posedge clk);
    #1 check("t1_inflight", 64'(validA), 64'd1);
    #1 rst = 1'b0; rd_req = 1'b0;
    #1;
    check("t1_valid", 64'(validA), 64'd0);
    check("t1_dataA", 64'(dataA), 64'd0);
    check("t1_dataB", 64'(dataB), 64'd0);
    check("t1_err", 64'(errA), 64'd0);
    check("t1_running", 64'(runA), 64'd0);
    check("t1_frozen", 64'(frzA), 64'd0);
    step();
    rst = 1'b1;
    step();
    doRead("t1_ch0", 4'd0, 32'd0, 8'd0, 1'b0);
    doRead("t1_cyc", 4'd8, 32'd0, 8'd0, 1'b0);
    endRead();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
